cwe1234_lock_arbiter: RTL and testbench

Write arbiter and lock controller for a bank of lockable configuration registers shared by a host port and a debug port. Enforces per-register sticky lock bits for host writes and lets debug writes bypass locks only during a key-authenticated, time-limited debug session. Sits between the bus-facing requesters and the register bank; the bank contents and lock status are exposed as outputs.

---
 rtl/cwe1234_lock_pkg.sv | 29 ++
 rtl/cwe1234_lock_arbiter_if.sv | 33 +++
 rtl/cwe1234_unlock_fsm.sv | 88 ++++++++
 rtl/cwe1234_lock_arbiter.sv | 103 ++++++++++
 tb/tb_cwe1234_lock_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cwe1234_lock_pkg.sv
// Shared types for the lockable register arbiter: unlock FSM states,
// arbitration port identifiers and the default debug key.
package cwe1234_lock_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } unlock_state_e;

    typedef enum logic {
        PORT_HOST = 1'b0,
        PORT_DBG  = 1'b1
    } port_sel_e;

    localparam logic [15:0] DEFAULT_KEY = 16'hA5C3;

    function automatic port_sel_e other_port(input port_sel_e p);
        port_sel_e r;
        case (p)
            PORT_HOST: r = PORT_DBG;
            PORT_DBG:  r = PORT_HOST;
            default:   r = PORT_HOST;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cwe1234_lock_arbiter_if.sv
// Host/debug request bundle for the lock arbiter; master = requesters, slave = arbiter.
interface cwe1234_lock_arbiter_if #(
    parameter int AW     = 2,
    parameter int DATA_W = 16
);
    logic              host_req;
    logic [AW-1:0]     host_addr;
    logic [DATA_W-1:0] host_data;
    logic              host_lock;
    logic              host_gnt;
    logic              host_err;
    logic              dbg_req;
    logic [AW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_gnt;
    logic              dbg_err;
    logic              dbg_unlock_req;
    logic [DATA_W-1:0] dbg_key;
    logic              dbg_unlocked;
    logic              dbg_lockout;

    modport master (
        output host_req, host_addr, host_data, host_lock,
        output dbg_req, dbg_addr, dbg_data, dbg_unlock_req, dbg_key,
        input  host_gnt, host_err, dbg_gnt, dbg_err, dbg_unlocked, dbg_lockout
    );

    modport slave (
        input  host_req, host_addr, host_data, host_lock,
        input  dbg_req, dbg_addr, dbg_data, dbg_unlock_req, dbg_key,
        output host_gnt, host_err, dbg_gnt, dbg_err, dbg_unlocked, dbg_lockout
    );
endinterface

// File: rtl/cwe1234_unlock_fsm.sv
// Debug unlock controller: key check, wrong-key counter with permanent lockout,
// and a fixed-length session timer. Status outputs lag the state by one flop.
module cwe1234_unlock_fsm
    import cwe1234_lock_pkg::*;
#(
    parameter int                DATA_W        = 16,
    parameter logic [DATA_W-1:0] UNLOCK_KEY    = DEFAULT_KEY,
    parameter int                MAX_FAILS     = 3,
    parameter int                DEBUG_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              unlock_req,
    input  logic [DATA_W-1:0] key,
    output logic              dbg_unlocked,
    output logic              dbg_lockout
);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = $clog2(DEBUG_TIMEOUT + 2);

    unlock_state_e     state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [FW-1:0]     fail_q, fail_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              unlocked_q, lockout_q;

    // Next-state logic for the unlock sequence
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        case (state_q)
            ST_LOCKED: begin
                if (unlock_req) begin
                    key_d   = key;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            ST_CHECK: begin
                if (key_q == UNLOCK_KEY) begin
                    fail_d  = FW'(0);
                    timer_d = TW'(DEBUG_TIMEOUT);
                    state_d = ST_UNLOCKED;
                end else if (fail_q == FW'(MAX_FAILS - 1)) begin
                    fail_d  = fail_q + FW'(1);
                    state_d = ST_LOCKOUT;
                end else begin
                    fail_d  = fail_q + FW'(1);
                    state_d = ST_LOCKED;
                end
            end
            ST_UNLOCKED: begin
                if (timer_q == TW'(0)) begin
                    state_d = ST_LOCKED;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_LOCKOUT: state_d = ST_LOCKOUT;
            default:    state_d = ST_LOCKED;
        endcase
    end

    // State and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOCKED;
            key_q      <= {DATA_W{1'b0}};
            fail_q     <= FW'(0);
            timer_q    <= TW'(0);
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            unlocked_q <= (state_q == ST_UNLOCKED);
            lockout_q  <= (state_q == ST_LOCKOUT);
        end
    end

    assign dbg_unlocked = unlocked_q;
    assign dbg_lockout  = lockout_q;
endmodule

// File: rtl/cwe1234_lock_arbiter.sv
// Host/debug write arbiter in front of a bank of registers with sticky host lock bits;
// debug writes bypass locks only while an authenticated session is active.
module cwe1234_lock_arbiter
    import cwe1234_lock_pkg::*;
#(
    parameter int                NUM_REGS      = 4,
    parameter int                DATA_W        = 16,
    parameter logic [DATA_W-1:0] UNLOCK_KEY    = DEFAULT_KEY,
    parameter int                MAX_FAILS     = 3,
    parameter int                DEBUG_TIMEOUT = 255
) (
    input  logic                       Clk,
    input  logic                       reset,
    cwe1234_lock_arbiter_if.slave      bus,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic [NUM_REGS-1:0]        lock_status
);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             lock_q, lock_d;
    port_sel_e                       rr_q, rr_d;
    logic host_gnt_q, host_gnt_d, host_err_q, host_err_d;
    logic dbg_gnt_q, dbg_gnt_d, dbg_err_q, dbg_err_d;
    logic host_elig_s, dbg_elig_s, dbg_unlocked_s, dbg_lockout_s;

    cwe1234_unlock_fsm #(
        .DATA_W       (DATA_W),
        .UNLOCK_KEY   (UNLOCK_KEY),
        .MAX_FAILS    (MAX_FAILS),
        .DEBUG_TIMEOUT(DEBUG_TIMEOUT)
    ) u_unlock (
        .clk         (Clk),
        .rst         (reset),
        .unlock_req  (bus.dbg_unlock_req),
        .key         (bus.dbg_key),
        .dbg_unlocked(dbg_unlocked_s),
        .dbg_lockout (dbg_lockout_s)
    );

    // A request held through its own completion cycle is not served twice
    assign host_elig_s = bus.host_req & ~host_gnt_q & ~host_err_q;
    assign dbg_elig_s  = bus.dbg_req & ~dbg_gnt_q & ~dbg_err_q;

    // Pick one winner per cycle and compute the resulting bank update
    always_comb begin
        regs_d     = regs_q;
        lock_d     = lock_q;
        rr_d       = rr_q;
        host_gnt_d = 1'b0;
        host_err_d = 1'b0;
        dbg_gnt_d  = 1'b0;
        dbg_err_d  = 1'b0;
        if (host_elig_s && (!dbg_elig_s || rr_q == PORT_HOST)) begin
            rr_d = other_port(PORT_HOST);
            if (!lock_q[bus.host_addr]) begin
                regs_d[bus.host_addr] = bus.host_data;
                lock_d[bus.host_addr] = bus.host_lock;
                host_gnt_d            = 1'b1;
            end else begin
                host_err_d = 1'b1;
            end
        end else if (dbg_elig_s) begin
            rr_d = other_port(PORT_DBG);
            if (dbg_unlocked_s) begin
                regs_d[bus.dbg_addr] = bus.dbg_data;
                dbg_gnt_d            = 1'b1;
            end else begin
                dbg_err_d = 1'b1;
            end
        end else begin
            rr_d = rr_q;
        end
    end

    // Bank, lock bits, round-robin pointer and completion pulses
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            regs_q     <= {(NUM_REGS*DATA_W){1'b0}};
            lock_q     <= {NUM_REGS{1'b0}};
            rr_q       <= PORT_HOST;
            host_gnt_q <= 1'b0;
            host_err_q <= 1'b0;
            dbg_gnt_q  <= 1'b0;
            dbg_err_q  <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            lock_q     <= lock_d;
            rr_q       <= rr_d;
            host_gnt_q <= host_gnt_d;
            host_err_q <= host_err_d;
            dbg_gnt_q  <= dbg_gnt_d;
            dbg_err_q  <= dbg_err_d;
        end
    end

    assign bus.host_gnt     = host_gnt_q;
    assign bus.host_err     = host_err_q;
    assign bus.dbg_gnt      = dbg_gnt_q;
    assign bus.dbg_err      = dbg_err_q;
    assign bus.dbg_unlocked = dbg_unlocked_s;
    assign bus.dbg_lockout  = dbg_lockout_s;
    assign reg_out          = regs_q;
    assign lock_status      = lock_q;
endmodule

// File: tb/tb_cwe1234_lock_arbiter.sv
// Directed + randomized bench for the lock arbiter, checked against an edge-counting
// behavioural model (register array, lock mask, session windows as edge ranges).
module tb_cwe1234_lock_arbiter;
    localparam int          NR      = 4;
    localparam int          DW      = 16;
    localparam int          AW      = 2;
    localparam logic [15:0] KEY     = 16'hA5C3;
    localparam int          SESSION = 256;
    localparam int          NEVER   = 32'h3fff_ffff;

    logic             Clk = 1'b0;
    logic             reset;
    logic [NR*DW-1:0] reg_out;
    logic [NR-1:0]    lock_status;

    cwe1234_lock_arbiter_if #(.AW(AW), .DATA_W(DW)) bus ();

    cwe1234_lock_arbiter #(
        .NUM_REGS(NR), .DATA_W(DW), .UNLOCK_KEY(KEY), .MAX_FAILS(3), .DEBUG_TIMEOUT(255)
    ) dut (
        .Clk(Clk), .reset(reset), .bus(bus.slave), .reg_out(reg_out), .lock_status(lock_status)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_lock;
    logic m_hg, m_he, m_dg, m_de;
    int last_port, sess_start, sess_end, fails, lockout_at, free_at;

    function automatic bit m_unl(input int e);
        return (sess_start <= e) && (e < sess_end);
    endfunction

    function automatic logic [DW-1:0] wrong_key();
        logic [DW-1:0] k;
        k = DW'($urandom);
        if (k == KEY) k = ~k;
        return k;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_lock = '0;
        {m_hg, m_he, m_dg, m_de} = 4'b0000;
        last_port  = 1;
        sess_start = 0;
        sess_end   = 0;
        fails      = 0;
        lockout_at = NEVER;
        free_at    = 0;
    endtask

    // Apply the rules for the upcoming clock edge using the currently driven inputs
    task automatic model_edge();
        bit he, de, perm;
        int win, e;
        e    = ecnt + 1;
        he   = bus.host_req && !(m_hg || m_he);
        de   = bus.dbg_req && !(m_dg || m_de);
        perm = m_unl(ecnt);
        win  = -1;
        if (he && de) win = (last_port == 0) ? 1 : 0;
        else if (he)  win = 0;
        else if (de)  win = 1;
        {m_hg, m_he, m_dg, m_de} = 4'b0000;
        if (win == 0) begin
            last_port = 0;
            if (!m_lock[bus.host_addr]) begin
                m_regs[bus.host_addr] = bus.host_data;
                if (bus.host_lock) m_lock[bus.host_addr] = 1'b1;
                m_hg = 1'b1;
            end else m_he = 1'b1;
        end else if (win == 1) begin
            last_port = 1;
            if (perm) begin
                m_regs[bus.dbg_addr] = bus.dbg_data;
                m_dg = 1'b1;
            end else m_de = 1'b1;
        end
        if (bus.dbg_unlock_req && e >= free_at) begin
            if (bus.dbg_key == KEY) begin
                sess_start = e + 2;
                sess_end   = e + 2 + SESSION;
                free_at    = e + 2 + SESSION;
                fails      = 0;
            end else begin
                fails++;
                if (fails == 3) begin
                    lockout_at = e + 2;
                    free_at    = NEVER;
                end else free_at = e + 2;
            end
        end
        ecnt = e;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NR*DW-1:0] er;
        for (int i = 0; i < NR; i++) er[i*DW +: DW] = m_regs[i];
        chk("host_gnt", 64'(bus.host_gnt), 64'(m_hg));
        chk("host_err", 64'(bus.host_err), 64'(m_he));
        chk("dbg_gnt", 64'(bus.dbg_gnt), 64'(m_dg));
        chk("dbg_err", 64'(bus.dbg_err), 64'(m_de));
        chk("reg_out", 64'(reg_out), 64'(er));
        chk("lock_status", 64'(lock_status), 64'(m_lock));
        chk("dbg_unlocked", 64'(bus.dbg_unlocked), 64'(m_unl(ecnt)));
        chk("dbg_lockout", 64'(bus.dbg_lockout), 64'(ecnt >= lockout_at));
    endtask

    task automatic idle();
        bus.host_req = 1'b0; bus.host_addr = '0; bus.host_data = '0; bus.host_lock = 1'b0;
        bus.dbg_req = 1'b0; bus.dbg_addr = '0; bus.dbg_data = '0;
        bus.dbg_unlock_req = 1'b0; bus.dbg_key = '0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clk);
        @(negedge Clk);
        check_all();
    endtask

    task automatic pulse(input logic [DW-1:0] k);
        bus.dbg_unlock_req = 1'b1;
        bus.dbg_key        = k;
        tick();
        bus.dbg_unlock_req = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge Clk);
        @(negedge Clk);
        idle();
        reset = 1'b0;
    endtask

    int ucount;

    initial begin
        idle();
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_all();
        reset = 1'b0;

        // Locked host write: first granted and locks, second rejected
        bus.host_req = 1'b1; bus.host_addr = 2'd2; bus.host_data = 16'h1234; bus.host_lock = 1'b1;
        tick();
        chk("t1_first_gnt", 64'(bus.host_gnt), 64'd1);
        bus.host_req = 1'b0;
        tick();
        bus.host_req = 1'b1; bus.host_data = 16'hFFFF; bus.host_lock = 1'b0;
        tick();
        chk("t1_second_err", 64'(bus.host_err), 64'd1);
        bus.host_req = 1'b0;
        tick();
        chk("t1_reg2", 64'(reg_out[47:32]), 64'h1234);
        chk("t1_locks", 64'(lock_status), 64'b0100);

        // Debug write without a session is rejected
        bus.dbg_req = 1'b1; bus.dbg_addr = 2'd1; bus.dbg_data = DW'($urandom);
        tick();
        chk("dbg_nosession_err", 64'(bus.dbg_err), 64'd1);
        bus.dbg_req = 1'b0;
        tick();

        // Random host traffic
        repeat (20) begin
            bus.host_req  = 1'($urandom_range(0, 1));
            bus.host_addr = AW'($urandom);
            bus.host_data = DW'($urandom);
            bus.host_lock = ($urandom_range(0, 3) == 0);
            tick();
        end
        idle();
        tick();

        // Correct key: contended traffic, then boundary writes around session expiry
        pulse(KEY);
        ucount = (bus.dbg_unlocked === 1'b1) ? 1 : 0;
        for (int i = 0; i < 300; i++) begin
            if (i < 40) begin
                bus.host_req = 1'b1; bus.dbg_req = 1'b1;
                bus.host_addr = AW'($urandom); bus.host_data = DW'($urandom); bus.host_lock = 1'b0;
                bus.dbg_addr = AW'($urandom); bus.dbg_data = DW'($urandom);
            end else begin
                bus.host_req = 1'b0;
                bus.dbg_req  = (ecnt == sess_end - 1) || (ecnt == sess_end + 1);
                bus.dbg_addr = 2'd2;
                bus.dbg_data = DW'($urandom);
            end
            tick();
            if (bus.dbg_unlocked === 1'b1) ucount++;
            if (i < 40) chk("one_cpl_per_cycle",
                64'(bus.host_gnt + bus.host_err + bus.dbg_gnt + bus.dbg_err), 64'd1);
            if (ecnt == sess_end)     chk("last_cycle_gnt", 64'(bus.dbg_gnt), 64'd1);
            if (ecnt == sess_end + 2) chk("expired_err", 64'(bus.dbg_err), 64'd1);
        end
        chk("session_len", 64'(ucount), 64'd256);
        idle();

        // Two wrong keys, then the right one clears the fail count
        pulse(wrong_key());
        pulse(wrong_key());
        pulse(KEY);
        tick();
        chk("unlock_after_two_fails", 64'(bus.dbg_unlocked), 64'd1);
        repeat (260) tick();
        pulse(wrong_key());
        pulse(wrong_key());
        tick();
        chk("no_lockout_after_clear", 64'(bus.dbg_lockout), 64'd0);
        pulse(wrong_key());
        tick();
        chk("lockout_third_fail", 64'(bus.dbg_lockout), 64'd1);
        pulse(KEY);
        repeat (5) tick();
        chk("lockout_ignores_key", 64'(bus.dbg_unlocked), 64'd0);

        // Reset mid-session with a pending host request
        do_reset();
        tick();
        chk("lockout_cleared", 64'(bus.dbg_lockout), 64'd0);
        pulse(KEY);
        tick();
        chk("pre_reset_unlocked", 64'(bus.dbg_unlocked), 64'd1);
        bus.host_req = 1'b1; bus.host_addr = 2'd0; bus.host_data = 16'hBEEF;
        #2;
        do_reset();
        tick();
        chk("dropped_no_gnt", 64'(bus.host_gnt | bus.host_err), 64'd0);
        chk("post_reset_regs", 64'(reg_out), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
